slow_pulse_req_fifo: RTL
========================

# slow_pulse_req_fifo

Fast-clock-domain request buffer that directly consumes the single-cycle strobes produced by the slow-to-fast pulse converter. Each strobe, together with the payload word sampled alongside it, is written into a small circular FIFO. The FIFO presents entries to the fast-side cache controller over a valid/ready handshake. Strobes that arrive while the FIFO is full are dropped, and the drop is recorded in a sticky overflow flag.

## Interface
- DATA_WIDTH, 32, payload width in bits
- DEPTH, 4, number of entries; must be a power of two, minimum 2
- ADDR_BITS, 2, log2(DEPTH); pointer width
- clk_fast  input  1  fast clock; every flop is updated on its rising edge
- reset  input  1  asynchronous, active-low reset; asserting it (0) clears state immediately, deassertion is synchronous to clk_fast
- pulse_in  input  1  push strobe; each cycle it is high counts as one push
- data_in  input  DATA_WIDTH  payload, sampled on the edge where pulse_in=1
- out_valid  output  1  FIFO holds at least one entry
- out_data  output  DATA_WIDTH  head entry; forced to 0 while out_valid=0
- out_ready  input  1  consumer accepts the head entry this cycle
- full  output  1  count == DEPTH
- count  output  ADDR_BITS+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a push was dropped; cleared only by reset

## Operation
- Storage: DEPTH x DATA_WIDTH register array, plus wr_ptr and rd_ptr (each ADDR_BITS wide, wrapping modulo DEPTH) and count (ADDR_BITS+1 bits).
- push_ok = pulse_in & (~full | pop).
- pop = out_valid & out_ready. If out_valid=0, out_ready is ignored.
- On push_ok:
  - mem[wr_ptr] <= data_in
  - wr_ptr <= wr_ptr+1
- On pop: rd_ptr <= rd_ptr+1.
- count update:
  - +1 on push_ok without pop
  - −1 on pop without push_ok
  - unchanged when both or neither occur
- Full with simultaneous push and pop: both are performed. count stays DEPTH and overflow does not set.
- Full with push and no pop: data is discarded, pointers are unchanged, overflow <= 1.
- Empty with push and out_ready=1: the push is performed and no pop occurs, since there is no bypass path. The entry becomes visible the next cycle.
- Output views:
  - out_valid = (count != 0)
  - full = (count == DEPTH)
  - out_data = out_valid ? mem[rd_ptr] : 0
  - All three are combinational decodes of registered state, with no input-to-output combinational path.
- Memory contents are not reset. Only pointers, count and overflow are reset.

## Timing
- Reset (reset=0), immediate and asynchronous:
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0
  - therefore out_valid=0, full=0, out_data=0
- Reset asserted mid-operation discards all buffered entries. The first push after reset deassertion lands in mem[0].
- Push latency: if pulse_in=1 at edge N, then from edge N onward out_valid=1 and out_data=data_in(N) when the FIFO was empty. Latency is one cycle.
- Pop: the entry is consumed at edge M where out_valid=1 and out_ready=1. The next entry (or out_valid=0) appears after edge M.
- Throughput: one push and one pop per cycle, sustained.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble. Entry ordering is strictly FIFO.
- overflow rises on the edge of the dropped push and stays high until reset=0.

## Test plan
- Reset check:
  - Stimulus: hold reset=0 while pulse_in=1 and data_in=32'hAAAA_5555, then release.
  - Required response: during reset, out_valid=0, count=0, overflow=0 and out_data=0. After release with pulse_in=0, nothing is stored.
- Single push/pop:
  - Stimulus: pulse_in one cycle with data_in=32'h1234_5678, out_ready=0.
  - Required response: the next cycle shows out_valid=1, out_data=32'h1234_5678, count=1. Raising out_ready for one cycle then gives out_valid=0, count=0, out_data=0.
- Fill and overflow:
  - Stimulus: DEPTH=4, out_ready=0, push 1,2,3,4,5 on consecutive cycles.
  - Required response: full=1 after the 4th push. The 5th push gives overflow=1 with count=4. Draining yields 1,2,3,4, and overflow remains 1.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full holding 1..4; in one cycle pulse_in=1 with data 9 and out_ready=1.
  - Required response: count stays 4, overflow stays 0, and the drain sequence is 2,3,4,9.
- Wrap-around streaming:
  - Stimulus: 10 pushes of data values 0..9, one per cycle, with out_ready=1 throughout.
  - Required response: every value appears exactly once, in order, one cycle after its push. count never exceeds 1 and the pointers wrap twice.
- Reset mid-stream:
  - Stimulus: with 3 entries held, pulse reset=0 for one half-cycle between edges, then push data value 7.
  - Required response: count=0 immediately on reset assertion. After the push, out_data=7 is read from mem[0].

Source files
------------

// File: rtl/slow_pulse_req_fifo.sv
// Fast-domain request FIFO fed by single-cycle strobes from the slow-to-fast
// pulse converter. Entries are offered to the cache controller over a
// valid/ready handshake; strobes that find the FIFO full are dropped and
// recorded in a sticky overflow flag.
module slow_pulse_req_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_BITS  = 2
) (
  input  logic                  clk_fast,
  input  logic                  reset,
  input  logic                  pulse_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  full,
  output logic [ADDR_BITS:0]    count,
  output logic                  overflow
);

  localparam logic [ADDR_BITS:0]   CNT_FULL = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   CNT_ONE  = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]    count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  pop;
  logic                  push_ok;

  // Output views decode registered state only; no input reaches an output.
  assign out_valid = (count_q != '0);
  assign full      = (count_q == CNT_FULL);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign pop     = out_valid & out_ready;
  assign push_ok = pulse_in & (~full | pop);

  // Next-state for pointers, occupancy and the sticky drop flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push_ok && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push_ok) begin
      count_d = count_q - CNT_ONE;
    end
    if (pulse_in && !push_ok) begin
      overflow_d = 1'b1;
    end
  end

  // Control state register; asynchronous clear on reset assertion.
  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage is deliberately not reset; occupancy gates visibility.
  always_ff @(posedge clk_fast) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule
